// File: rtl/typed_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one typed ndata stream between NUM_REQ requesters.
// The granted type token is registered and held stable for the whole packet.
module typed_stream_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int TYPE_WIDTH   = 8,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW  = NUM_ELEMENTS * DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_type_valid,
  output logic [NUM_REQ-1:0]               req_type_ready,
  input  logic [NUM_REQ*TYPE_WIDTH-1:0]    req_type_data,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*BW-1:0]            req_data,
  input  logic [NUM_REQ*NUM_ELEMENTS-1:0]  req_keep,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic                             out_type_valid,
  input  logic                             out_type_ready,
  output logic [TYPE_WIDTH-1:0]            out_type_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BW-1:0]                    out_data,
  output logic [NUM_ELEMENTS-1:0]          out_keep,
  output logic                             out_last,
  output logic [IDW-1:0]                   grant_id,
  output logic                             busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]          grant_id_q, grant_id_d;
  logic [TYPE_WIDTH-1:0]   type_q, type_d;
  logic                    type_done_q, type_done_d;
  logic                    data_done_q, data_done_d;

  logic                    found;
  logic [IDW-1:0]          pick;
  logic [IDW-1:0]          idx;

  logic [TYPE_WIDTH-1:0]   type_arr [NUM_REQ];
  logic [BW-1:0]           data_arr [NUM_REQ];
  logic [NUM_ELEMENTS-1:0] keep_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign type_arr[gi] = req_type_data[gi*TYPE_WIDTH +: TYPE_WIDTH];
      assign data_arr[gi] = req_data[gi*BW +: BW];
      assign keep_arr[gi] = req_keep[gi*NUM_ELEMENTS +: NUM_ELEMENTS];
    end
  endgenerate

  // Round-robin search: first valid type token at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_type_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    type_d         = type_q;
    type_done_d    = type_done_q;
    data_done_d    = data_done_q;
    req_type_ready = '0;
    req_ready      = '0;
    out_type_valid = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_keep       = '0;
    out_last       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          // Gated by rst_n so nothing is accepted while reset is held.
          req_type_ready[pick] = rst_n;
          type_d      = type_arr[pick];
          grant_id_d  = pick;
          rr_ptr_d    = IDW'((int'(pick) + 1) % NUM_REQ);
          type_done_d = 1'b0;
          data_done_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        out_type_valid        = ~type_done_q;
        out_valid             = req_valid[grant_id_q] & ~data_done_q;
        out_data              = data_arr[grant_id_q];
        out_keep              = keep_arr[grant_id_q];
        out_last              = req_last[grant_id_q];
        req_ready[grant_id_q] = out_ready & ~data_done_q;
        if (out_type_valid && out_type_ready) type_done_d = 1'b1;
        if (out_valid && out_ready && out_last) data_done_d = 1'b1;
        // Leave as soon as both handshakes are complete; the next grant happens in IDLE.
        if (type_done_d && data_done_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      type_q      <= '0;
      type_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      type_q      <= type_d;
      type_done_q <= type_done_d;
      data_done_q <= data_done_d;
    end
  end

  assign out_type_data = type_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q == BUSY);

endmodule

// File: tb/tb_typed_stream_arbiter.sv
// Directed bench for typed_stream_arbiter: 4 requesters, 2 x 16-bit elements per beat.
// Upstream sources and the downstream sink are modelled by the cycle task.
module tb_typed_stream_arbiter;

  localparam int NR = 4;
  localparam int NE = 2;
  localparam int DW = 16;
  localparam int TW = 8;
  localparam int BW = NE * DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_type_valid, req_type_ready;
  logic [NR*TW-1:0] req_type_data;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*BW-1:0] req_data;
  logic [NR*NE-1:0] req_keep;
  logic [NR-1:0]   req_last;
  logic            out_type_valid, out_type_ready;
  logic [TW-1:0]   out_type_data;
  logic            out_valid, out_ready;
  logic [BW-1:0]   out_data;
  logic [NE-1:0]   out_keep;
  logic            out_last;
  logic [1:0]      grant_id;
  logic            busy;

  typed_stream_arbiter #(
    .NUM_REQ(NR), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .TYPE_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_type_valid(req_type_valid), .req_type_ready(req_type_ready),
    .req_type_data(req_type_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_keep(req_keep), .req_last(req_last),
    .out_type_valid(out_type_valid), .out_type_ready(out_type_ready),
    .out_type_data(out_type_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Source model: type valid, type value, beats per packet, beat index, extra packets.
  logic [NR-1:0] tv;
  logic [TW-1:0] ty [NR];
  int            nb [NR];
  int            bi [NR];
  int            pk [NR];
  bit            tog;

  logic [BW-1:0] obs_data [$];
  logic [NE-1:0] obs_keep [$];
  logic          obs_last [$];
  int            obs_gid  [$];
  logic [TW-1:0] obs_type [$];
  logic [TW-1:0] typ_log  [$];

  function automatic logic [BW-1:0] mk(input int r, input int b);
    logic [15:0] hi, lo;
    hi = 16'hA000 + 16'(r * 16 + b);
    lo = 16'h5000 + 16'(r * 256 + b);
    return {hi, lo};
  endfunction

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      req_type_valid[r]           = tv[r];
      req_type_data[r*TW +: TW]   = ty[r];
      req_valid[r]                = (bi[r] < nb[r]);
      req_last[r]                 = (nb[r] > 0) && (bi[r] == nb[r] - 1);
      req_data[r*BW +: BW]        = mk(r, bi[r]);
      req_keep[r*NE +: NE]        = ((nb[r] > 0) && (bi[r] == nb[r] - 1)) ? 2'b01 : 2'b11;
    end
  endtask

  task automatic model_clear();
    tv = '0;
    for (int r = 0; r < NR; r++) begin
      ty[r] = '0; nb[r] = 0; bi[r] = 0; pk[r] = 0;
    end
  endtask

  task automatic obs_clear();
    obs_data.delete(); obs_keep.delete(); obs_last.delete();
    obs_gid.delete(); obs_type.delete(); typ_log.delete();
  endtask

  // Record this cycle's handshakes, advance one clock, update sources, settle.
  task automatic cycle();
    logic [NR-1:0] thx, dhx;
    thx = req_type_valid & req_type_ready;
    dhx = req_valid & req_ready;
    if (out_valid && out_ready) begin
      obs_data.push_back(out_data);
      obs_keep.push_back(out_keep);
      obs_last.push_back(out_last);
      obs_gid.push_back(int'(grant_id));
      obs_type.push_back(out_type_data);
    end
    if (out_type_valid && out_type_ready) typ_log.push_back(out_type_data);
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (thx[r]) tv[r] = 1'b0;
      if (dhx[r]) begin
        if (bi[r] == nb[r] - 1) begin
          bi[r] = 0;
          if (pk[r] > 0) begin
            pk[r]--;
            tv[r] = 1'b1;
          end else begin
            nb[r] = 0;
          end
        end else begin
          bi[r]++;
        end
      end
    end
    if (tog) out_ready = ~out_ready;
    drive();
    #1;
  endtask

  task automatic test_reset();
    tv = 4'b1111;
    for (int r = 0; r < NR; r++) begin ty[r] = 8'h10 + 8'(r); nb[r] = 1; end
    drive();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    tests++; if (out_type_data !== 8'h00) begin fails++; $display("FAIL reset_type_data got=%h exp=00", out_type_data); end
    tests++; if (out_type_valid !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valids got type_valid=%b valid=%b exp=0/0", out_type_valid, out_valid);
    end
    tests++; if (req_type_ready !== 4'b0000 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_readys got type_ready=%b ready=%b exp=0000/0000", req_type_ready, req_ready);
    end
    model_clear();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    cycle();
    tests++; if (busy !== 1'b0 || req_type_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_idle got busy=%b type_ready=%b exp=0/0000", busy, req_type_ready);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] exp_ty [NR];
    int k;
    exp_ty[0] = 8'h11; exp_ty[1] = 8'h22; exp_ty[2] = 8'h33; exp_ty[3] = 8'h44;
    obs_clear();
    out_ready = 1'b1; out_type_ready = 1'b1; tog = 1'b0;
    tv = 4'b1111;
    for (int r = 0; r < NR; r++) begin ty[r] = exp_ty[r]; nb[r] = 2; bi[r] = 0; end
    drive();
    #1;
    tests++; if (req_type_ready !== 4'b0001) begin
      fails++; $display("FAIL rr_first_grant got=%b exp=0001", req_type_ready);
    end
    for (k = 0; k < 60 && obs_data.size() < 8; k++) cycle();
    tests++; if (obs_data.size() != 8 || k != 12) begin
      fails++; $display("FAIL rr_timing got beats=%0d cycles=%0d exp=8/12", obs_data.size(), k);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < obs_data.size()) begin
        int r, b;
        r = i / 2; b = i % 2;
        tests++;
        if (obs_data[i] !== mk(r, b) || obs_last[i] !== (b == 1) || obs_gid[i] != r ||
            obs_type[i] !== exp_ty[r] || obs_keep[i] !== ((b == 1) ? 2'b01 : 2'b11)) begin
          fails++;
          $display("FAIL rr_beat%0d got data=%h last=%b gid=%0d type=%h keep=%b exp data=%h gid=%0d type=%h",
                   i, obs_data[i], obs_last[i], obs_gid[i], obs_type[i], obs_keep[i], mk(r, b), r, exp_ty[r]);
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      tests++;
      if (i >= typ_log.size() || typ_log[i] !== exp_ty[i]) begin
        fails++; $display("FAIL rr_type%0d got=%h exp=%h", i, (i < typ_log.size()) ? typ_log[i] : 8'hxx, exp_ty[i]);
      end
    end
    $display("[TB] test_round_robin done: %0d beats", obs_data.size());
  endtask

  task automatic test_backpressure();
    int k;
    obs_clear();
    out_ready = 1'b1; out_type_ready = 1'b0; tog = 1'b1;
    tv[2] = 1'b1; ty[2] = 8'h33; nb[2] = 5; bi[2] = 0;
    drive();
    #1;
    tests++; if (req_type_ready !== 4'b0100) begin
      fails++; $display("FAIL bp_grant got=%b exp=0100", req_type_ready);
    end
    cycle();
    for (k = 1; k <= 40 && obs_data.size() < 5; k++) begin
      out_type_ready = (k >= 4);
      #1;
      tests++;
      if (busy !== 1'b1 || grant_id !== 2'd2 || out_type_data !== 8'h33 || out_valid !== 1'b1 ||
          out_type_valid !== (k <= 4) || req_ready !== (out_ready ? 4'b0100 : 4'b0000)) begin
        fails++;
        $display("FAIL bp_cycle%0d got busy=%b gid=%0d type=%h valid=%b tvalid=%b ready=%b exp 1/2/33/1/%b/%b",
                 k, busy, grant_id, out_type_data, out_valid, out_type_valid, req_ready,
                 (k <= 4), (out_ready ? 4'b0100 : 4'b0000));
      end
      cycle();
    end
    tests++; if (obs_data.size() != 5) begin
      fails++; $display("FAIL bp_timeout got beats=%0d exp=5", obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < 5; i++) begin
      tests++;
      if (obs_data[i] !== mk(2, i) || obs_last[i] !== (i == 4)) begin
        fails++; $display("FAIL bp_beat%0d got data=%h last=%b exp data=%h last=%b",
                          i, obs_data[i], obs_last[i], mk(2, i), (i == 4));
      end
    end
    tests++; if (typ_log.size() != 1 || typ_log[0] !== 8'h33) begin
      fails++; $display("FAIL bp_type_once got count=%0d exp=1 (0x33)", typ_log.size());
    end
    tog = 1'b0; out_ready = 1'b1;
    $display("[TB] test_backpressure done: %0d beats", obs_data.size());
  endtask

  task automatic test_single_beat();
    obs_clear();
    out_ready = 1'b1; out_type_ready = 1'b1; tog = 1'b0;
    tv[1] = 1'b1; ty[1] = 8'h5A; nb[1] = 1; bi[1] = 0;
    drive();
    #1;
    tests++; if (req_type_ready !== 4'b0010) begin
      fails++; $display("FAIL sb_grant1 got=%b exp=0010", req_type_ready);
    end
    cycle();
    tv[3] = 1'b1; ty[3] = 8'hC3; nb[3] = 1; bi[3] = 0;
    drive();
    #1;
    tests++;
    if (busy !== 1'b1 || grant_id !== 2'd1 || out_valid !== 1'b1 || out_last !== 1'b1 ||
        out_type_valid !== 1'b1 || req_type_ready !== 4'b0000) begin
      fails++; $display("FAIL sb_beat got busy=%b gid=%0d valid=%b last=%b tvalid=%b tready=%b exp 1/1/1/1/1/0000",
                        busy, grant_id, out_valid, out_last, out_type_valid, req_type_ready);
    end
    cycle();
    tests++;
    if (busy !== 1'b0 || req_type_ready !== 4'b1000 || out_valid !== 1'b0) begin
      fails++; $display("FAIL sb_exit got busy=%b tready=%b valid=%b exp 0/1000/0", busy, req_type_ready, out_valid);
    end
    cycle();
    tests++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || out_type_data !== 8'hC3) begin
      fails++; $display("FAIL sb_grant3 got busy=%b gid=%0d type=%h exp 1/3/c3", busy, grant_id, out_type_data);
    end
    cycle();
    tests++;
    if (obs_gid.size() != 2 || obs_gid[0] != 1 || obs_gid[1] != 3 || typ_log.size() != 2) begin
      fails++; $display("FAIL sb_order got beats=%0d types=%0d exp beats from 1 then 3", obs_gid.size(), typ_log.size());
    end
    $display("[TB] test_single_beat done: %0d beats", obs_data.size());
  endtask

  task automatic test_data_before_type();
    int k;
    obs_clear();
    tv[0] = 1'b0; ty[0] = 8'h77; nb[0] = 3; bi[0] = 0;
    drive();
    #1;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (req_ready[0] !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL early_data%0d got ready0=%b valid=%b busy=%b exp 0/0/0", c, req_ready[0], out_valid, busy);
      end
      cycle();
    end
    tv[0] = 1'b1;
    drive();
    #1;
    tests++; if (req_type_ready !== 4'b0001) begin
      fails++; $display("FAIL early_grant got=%b exp=0001", req_type_ready);
    end
    for (k = 0; k < 20 && obs_data.size() < 3; k++) cycle();
    tests++; if (obs_data.size() != 3) begin
      fails++; $display("FAIL early_timeout got beats=%0d exp=3", obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      tests++;
      if (obs_data[i] !== mk(0, i) || obs_type[i] !== 8'h77) begin
        fails++; $display("FAIL early_beat%0d got data=%h type=%h exp data=%h type=77", i, obs_data[i], obs_type[i], mk(0, i));
      end
    end
    $display("[TB] test_data_before_type done: %0d beats", obs_data.size());
  endtask

  task automatic test_reset_mid_packet();
    int k;
    obs_clear();
    tv[2] = 1'b1; ty[2] = 8'h66; nb[2] = 6; bi[2] = 0;
    drive();
    #1;
    for (k = 0; k < 20 && obs_data.size() < 2; k++) cycle();
    tests++;
    if (out_valid !== 1'b1 || out_data !== mk(2, 2)) begin
      fails++; $display("FAIL mid_third_beat got valid=%b data=%h exp 1/%h", out_valid, out_data, mk(2, 2));
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_type_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 ||
        out_type_data !== 8'h00 || req_ready !== 4'b0000 || out_data !== '0) begin
      fails++; $display("FAIL mid_async_clear got valid=%b tvalid=%b busy=%b gid=%0d type=%h ready=%b data=%h exp all 0",
                        out_valid, out_type_valid, busy, grant_id, out_type_data, req_ready, out_data);
    end
    model_clear();
    drive();
    cycle();
    rst_n = 1'b1;
    obs_clear();
    tv[1] = 1'b1; ty[1] = 8'h91; nb[1] = 1;
    tv[3] = 1'b1; ty[3] = 8'h93; nb[3] = 1;
    drive();
    #1;
    tests++; if (req_type_ready !== 4'b0010 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_regrant got tready=%b busy=%b exp 0010/0", req_type_ready, busy);
    end
    for (k = 0; k < 20 && obs_data.size() < 2; k++) cycle();
    tests++;
    if (obs_gid.size() != 2 || obs_gid[0] != 1 || obs_gid[1] != 3 || obs_type[0] !== 8'h91) begin
      fails++; $display("FAIL mid_after got beats=%0d exp 2 beats from 1 (0x91) then 3", obs_gid.size());
    end
    $display("[TB] test_reset_mid_packet done: %0d beats", obs_data.size());
  endtask

  task automatic test_back_to_back();
    int k;
    obs_clear();
    tv[3] = 1'b1; ty[3] = 8'hB3; nb[3] = 2; bi[3] = 0; pk[3] = 3;
    drive();
    #1;
    for (int c = 0; c <= 12; c++) begin
      tests++;
      if (busy !== (c % 3 != 0) || (busy && grant_id !== 2'd3)) begin
        fails++; $display("FAIL b2b_cycle%0d got busy=%b gid=%0d exp busy=%b gid=3", c, busy, grant_id, (c % 3 != 0));
      end
      if (c < 12) cycle();
    end
    tests++; if (obs_data.size() != 8 || typ_log.size() != 4) begin
      fails++; $display("FAIL b2b_count got beats=%0d types=%0d exp 8/4", obs_data.size(), typ_log.size());
    end
    obs_clear();
    tv[0] = 1'b1; ty[0] = 8'hA0; nb[0] = 1; bi[0] = 0;
    tv[3] = 1'b1; ty[3] = 8'hA3; nb[3] = 1; bi[3] = 0;
    drive();
    #1;
    tests++; if (req_type_ready !== 4'b0001) begin
      fails++; $display("FAIL b2b_wrap got tready=%b exp=0001", req_type_ready);
    end
    for (k = 0; k < 20 && obs_data.size() < 2; k++) cycle();
    tests++; if (obs_gid.size() != 2 || obs_gid[0] != 0 || obs_gid[1] != 3) begin
      fails++; $display("FAIL b2b_wrap_order got beats=%0d exp 2 beats from 0 then 3", obs_gid.size());
    end
    $display("[TB] test_back_to_back done");
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0; out_type_ready = 1'b0; tog = 1'b0;
    req_type_valid = '0; req_type_data = '0; req_valid = '0;
    req_data = '0; req_keep = '0; req_last = '0;
    model_clear();
    drive();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_beat();
    test_data_before_type();
    test_reset_mid_packet();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
